// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner.
//   NUM_VEC  : number of input vectors of a 4-input function
//   IDX_W    : width of the vector index {a,b,c,d}
//   CNT_W    : width of the ones counter (holds 0..16)
//   SETTLE_W : width of the settle counter (SETTLE legal range 1..15)
//   state_e  : scanner FSM states
package truth_table_scanner_pkg;

  localparam int NUM_VEC  = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 5;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer: counts the cycles the vector is held before sampling.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : reload the counter with SETTLE
//   i_run      : count down (high while the scanner is driving a vector)
//   o_expire   : high in the last settle cycle, so the FSM leaves DRIVE
//                after exactly SETTLE cycles
module tt_settle_timer
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE);

  logic [SETTLE_W-1:0] r_cnt;

  // Down-counter: loaded on entry to DRIVE, decremented while driving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_run && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // A count of 1 marks the final DRIVE cycle.
  assign o_expire = i_run && (r_cnt == 4'd1);

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks {a,b,c,d} through 0..15, samples the returned
// function output s for each vector and compares the captured table with
// a reference table.
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_start              : begin a scan (only honoured in IDLE)
//   i_expected[15:0]     : reference truth table, read in DONE only
//   o_a, o_b, o_c, o_d   : vector under test, a is the MSB
//   i_s                  : function output for the current vector
//   o_busy               : scan in progress
//   o_done               : one-cycle completion pulse
//   o_table[15:0]        : captured truth table, bit i = s of vector i
//   o_ones_count[4:0]    : number of ones captured
//   o_match              : captured table equals the reference
// Every output comes straight from a flop. busy and done are registered
// from the state, so they trail the state register by one cycle.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [NUM_VEC-1:0] i_expected,
  output logic               o_a,
  output logic               o_b,
  output logic               o_c,
  output logic               o_d,
  input  logic               i_s,
  output logic               o_busy,
  output logic               o_done,
  output logic [NUM_VEC-1:0] o_table,
  output logic [CNT_W-1:0]   o_ones_count,
  output logic               o_match
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_VEC-1:0] r_table;
  logic [CNT_W-1:0]   r_ones;
  logic               r_busy;
  logic               r_done;
  logic               r_match;
  logic               w_load;
  logic               w_expire;
  logic               w_last;

  assign w_last = (r_idx == 4'd15);

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_run    (r_state == DRIVE),
    .o_expire (w_expire)
  );

  // Next-state logic and settle-timer reload requests.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = DRIVE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DRIVE: begin
        if (w_expire) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_state_nxt = DRIVE;
        end
      end
      SAMPLE: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRIVE;
          w_load      = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_table <= 16'h0000;
      r_ones  <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (r_state != IDLE);
      r_done  <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_idx   <= 4'd0;
            r_table <= 16'h0000;
            r_ones  <= 5'd0;
            r_match <= 1'b0;
          end else begin
            r_idx   <= r_idx;
            r_table <= r_table;
            r_ones  <= r_ones;
            r_match <= r_match;
          end
        end
        SAMPLE: begin
          r_table[r_idx] <= i_s;
          r_ones         <= r_ones + {4'd0, i_s};
          // idx stops at 15 so the outputs never show an out-of-range vector.
          if (!w_last) begin
            r_idx <= r_idx + 4'd1;
          end else begin
            r_idx <= r_idx;
          end
        end
        DONE: begin
          r_match <= (r_table == i_expected);
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  assign {o_a, o_b, o_c, o_d} = r_idx;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_table      = r_table;
  assign o_ones_count = r_ones;
  assign o_match      = r_match;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: one instance with SETTLE=1 and one with
// SETTLE=3; 'sel' chooses which one a scan targets. The function under test
// is a 16-bit table 'func' indexed by {a,b,c,d}.
module tb_truth_table_scanner;

  typedef struct {
    logic        which;
    logic [15:0] f;
    logic [15:0] e;
    logic [15:0] tbl;
    int          ones;
    logic        mt;
    int          dcyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sel;
  logic [15:0] func;
  logic [15:0] exp_v;

  logic        a1, b1, c1, d1, s1, busy1, done1, match1;
  logic [15:0] table1;
  logic [4:0]  ones1;
  logic        a3, b3, c3, d3, s3, busy3, done3, match3;
  logic [15:0] table3;
  logic [4:0]  ones3;

  logic        start1, start3;
  logic [3:0]  m_abcd;
  logic        m_busy, m_done, m_match;
  logic [15:0] m_table;
  logic [4:0]  m_ones;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign start1  = start & ~sel;
  assign start3  = start & sel;
  assign s1      = func[{a1, b1, c1, d1}];
  assign s3      = func[{a3, b3, c3, d3}];
  assign m_abcd  = sel ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
  assign m_busy  = sel ? busy3 : busy1;
  assign m_done  = sel ? done3 : done1;
  assign m_match = sel ? match3 : match1;
  assign m_table = sel ? table3 : table1;
  assign m_ones  = sel ? ones3 : ones1;

  truth_table_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_expected(exp_v),
    .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1), .i_s(s1),
    .o_busy(busy1), .o_done(done1), .o_table(table1),
    .o_ones_count(ones1), .o_match(match1)
  );

  truth_table_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start3), .i_expected(exp_v),
    .o_a(a3), .o_b(b3), .o_c(c3), .o_d(d3), .i_s(s3),
    .o_busy(busy3), .o_done(done3), .o_table(table3),
    .o_ones_count(ones3), .o_match(match3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  function automatic int popcnt16(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  // Start one scan, optionally re-pulse start at cycle 'repulse_at', and
  // observe a bounded window. Cycle n = the period after the n-th rising
  // edge following the edge that accepts start.
  task automatic run_scan(input logic which, input logic [15:0] f, input logic [15:0] e,
                          input int repulse_at, output int done_at, output int n_done,
                          output bit seq_ok, output logic [15:0] tbl,
                          output logic [4:0] ones, output logic mt);
    int seq[$];
    int v;
    int settle;
    int budget;
    settle = which ? 3 : 1;
    budget = 16 * (settle + 1) + 6;
    @(negedge clk);
    sel = which; func = f; exp_v = e; start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    done_at = -1;
    n_done  = 0;
    seq.delete();
    seq.push_back(int'(m_abcd));
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (m_done) begin
        n_done++;
        if (done_at < 0) done_at = n;
      end
      v = int'(m_abcd);
      if (v != seq[$]) seq.push_back(v);
      start = (n == repulse_at);
    end
    start  = 1'b0;
    seq_ok = (seq.size() == 16);
    for (int i = 0; i < seq.size(); i++) if (seq[i] != i) seq_ok = 1'b0;
    tbl  = m_table;
    ones = m_ones;
    mt   = m_match;
  endtask

  initial begin
    vec_t        vecs[6];
    int          done_at, n_done;
    bit          seq_ok;
    logic [15:0] tbl, f, e;
    logic [4:0]  ones;
    logic        mt;
    int          dq[$];
    int          bq[$];
    int          spurious;

    vecs[0] = '{1'b0, 16'hAC3C, 16'hAC3C, 16'hAC3C, 8,  1'b1, 33};
    vecs[1] = '{1'b0, 16'hAC3C, 16'hAC3D, 16'hAC3C, 8,  1'b0, 33};
    vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16, 1'b1, 65};
    vecs[3] = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 0,  1'b0, 65};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 0,  1'b1, 33};
    vecs[5] = '{1'b0, 16'h8001, 16'h8001, 16'h8001, 2,  1'b1, 33};

    rst_n = 1'b0; start = 1'b0; sel = 1'b0; func = 16'h0000; exp_v = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut1", {busy1, done1, match1, ones1, table1, a1, b1, c1, d1}, 32'd0);
    check("reset_dut3", {busy3, done3, match3, ones3, table3, a3, b3, c3, d3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_release", {busy1, done1, busy3, done3}, 32'd0);

    // Table-driven scans.
    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].which, vecs[i].f, vecs[i].e, -1, done_at, n_done, seq_ok, tbl, ones, mt);
      check($sformatf("vec%0d_done_cycle", i), done_at, vecs[i].dcyc);
      check($sformatf("vec%0d_done_count", i), n_done, 1);
      check($sformatf("vec%0d_abcd_seq", i), seq_ok, 1);
      check($sformatf("vec%0d_table", i), tbl, vecs[i].tbl);
      check($sformatf("vec%0d_ones", i), ones, vecs[i].ones);
      check($sformatf("vec%0d_match", i), mt, vecs[i].mt);
    end

    // Randomised scans against the model: table = function, ones = popcount,
    // match = equality, done after 16*(SETTLE+1)+1 cycles.
    for (int i = 0; i < 8; i++) begin
      logic w;
      w = (i >= 6);
      f = 16'($urandom);
      e = ($urandom_range(0, 1) == 1) ? f : (f ^ (16'h0001 << $urandom_range(0, 15)));
      run_scan(w, f, e, -1, done_at, n_done, seq_ok, tbl, ones, mt);
      check($sformatf("rnd%0d_done_cycle", i), done_at, 16 * ((w ? 3 : 1) + 1) + 1);
      check($sformatf("rnd%0d_table", i), tbl, f);
      check($sformatf("rnd%0d_ones", i), ones, popcnt16(f));
      check($sformatf("rnd%0d_match", i), mt, (f == e));
    end

    // start re-pulsed at cycle 10 is ignored.
    run_scan(1'b0, 16'hAC3C, 16'hAC3C, 10, done_at, n_done, seq_ok, tbl, ones, mt);
    check("repulse_done_cycle", done_at, 33);
    check("repulse_done_count", n_done, 1);
    check("repulse_abcd_seq", seq_ok, 1);
    check("repulse_table", tbl, 16'hAC3C);

    // Reset mid-scan at cycle 20.
    @(negedge clk);
    sel = 1'b0; func = 16'hAC3C; exp_v = 16'hAC3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_busy", busy1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midscan_reset_async", {busy1, done1, match1, ones1, table1, a1, b1, c1, d1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done1 || busy1) spurious++;
    end
    check("after_reset_stays_idle", spurious, 0);
    run_scan(1'b0, 16'hAC3C, 16'hAC3C, -1, done_at, n_done, seq_ok, tbl, ones, mt);
    check("post_reset_done_cycle", done_at, 33);
    check("post_reset_table", tbl, 16'hAC3C);
    check("post_reset_match", mt, 1);

    // start held high: back-to-back scans with one IDLE cycle between them.
    @(negedge clk);
    sel = 1'b0; func = 16'h5A5A; exp_v = 16'h5A5A; start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 110; n++) begin
      @(posedge clk); #1;
      if (done1) dq.push_back(n);
      if (!busy1 && n <= 66) bq.push_back(n);
      if (n == 99) start = 1'b0;
    end
    check("held_done_count", dq.size(), 3);
    if (dq.size() == 3) begin
      check("held_done_first", dq[0], 33);
      check("held_done_second", dq[1], 67);
      check("held_done_third", dq[2], 101);
    end
    check("held_busy_low_count", bq.size(), 1);
    if (bq.size() == 1) check("held_busy_low_cycle", bq[0], 34);
    check("held_table", table1, 16'h5A5A);
    check("held_match", match1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
